// File: rtl/counter_reload_ctrl_if.sv
// counter_reload_ctrl_if: bus bundle between the reload controller and its user.
// Ports: write/start/stop/mode and IRQ clear in; DATA/LOAD/ACTIVE/PEND/TICK/IRQ out.
// Optional match bus (MATCH_WR/MATCH_DATA/MATCH/CNT_O) under COUNTER_RELOAD_MATCH_EN.
interface counter_reload_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             WR_EN;
    logic [WIDTH-1:0] WR_DATA;
    logic             START;
    logic             STOP;
    logic             MODE;
    logic             CNT_COUT;
    logic [WIDTH-1:0] DATA;
    logic             LOAD;
    logic             ACTIVE;
    logic             PEND;
    logic             TICK;
    logic             IRQ;
    logic             IRQ_CLR;
`ifdef COUNTER_RELOAD_MATCH_EN
    logic             MATCH_WR;
    logic [WIDTH-1:0] MATCH_DATA;
    logic             MATCH;
    logic [WIDTH-1:0] CNT_O;

    modport master (
        output WR_EN, WR_DATA, START, STOP, MODE, CNT_COUT, IRQ_CLR,
        output MATCH_WR, MATCH_DATA, CNT_O,
        input  DATA, LOAD, ACTIVE, PEND, TICK, IRQ, MATCH
    );
    modport slave (
        input  WR_EN, WR_DATA, START, STOP, MODE, CNT_COUT, IRQ_CLR,
        input  MATCH_WR, MATCH_DATA, CNT_O,
        output DATA, LOAD, ACTIVE, PEND, TICK, IRQ, MATCH
    );
`else
    modport master (
        output WR_EN, WR_DATA, START, STOP, MODE, CNT_COUT, IRQ_CLR,
        input  DATA, LOAD, ACTIVE, PEND, TICK, IRQ
    );
    modport slave (
        input  WR_EN, WR_DATA, START, STOP, MODE, CNT_COUT, IRQ_CLR,
        output DATA, LOAD, ACTIVE, PEND, TICK, IRQ
    );
`endif
endinterface

// File: rtl/counter_reload_ctrl.sv
// counter_reload_ctrl: periodic / one-shot reload sequencer for a loadable counter.
// Ports: CLK, RESET (sync, active-high), bus (slave side of counter_reload_ctrl_if).
// Optional match comparator enabled by defining COUNTER_RELOAD_MATCH_EN.
module counter_reload_ctrl #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RELOAD_INIT = '0
) (
    input logic                  CLK,
    input logic                  RESET,
    counter_reload_ctrl_if.slave bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_pending;
    logic             r_pend;
    logic             r_mode;
    logic             r_tick;
    logic             r_irq;

    logic w_run;
    logic w_stop;
    logic w_bound;
    logic w_exit;

    assign w_run   = (r_state == S_RUN);
    assign w_stop  = w_run & bus.STOP;
    // A boundary cut short by STOP is not a period end.
    assign w_bound = w_run & ~bus.STOP & bus.CNT_COUT;
    assign w_exit  = w_stop | (w_bound & r_mode);

    assign bus.DATA   = r_active;
    assign bus.LOAD   = RESET | ~w_run | bus.STOP | bus.CNT_COUT;
    assign bus.ACTIVE = w_run;
    assign bus.PEND   = r_pend;
    assign bus.TICK   = r_tick;
    assign bus.IRQ    = r_irq;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_active  <= RELOAD_INIT;
            r_pending <= '0;
            r_pend    <= 1'b0;
            r_mode    <= 1'b0;
            r_tick    <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_tick <= w_bound;
            // Holding set through the TICK cycle lets a clear there lose.
            r_irq  <= w_bound | r_tick | (r_irq & ~bus.IRQ_CLR);
            if (r_state == S_IDLE) begin
                if (bus.WR_EN)
                    r_active <= bus.WR_DATA;
                if (bus.START && !bus.STOP) begin
                    r_mode  <= bus.MODE;
                    r_state <= S_RUN;
                end
            end else if (w_exit) begin
                // Leaving RUNNING: fold any pending value in, newest wins.
                r_state <= S_IDLE;
                r_pend  <= 1'b0;
                if (bus.WR_EN)
                    r_active <= bus.WR_DATA;
                else if (r_pend)
                    r_active <= r_pending;
            end else begin
                if (w_bound && r_pend) begin
                    r_active <= r_pending;
                    r_pend   <= 1'b0;
                end
                // Written last so a boundary-cycle write stays pending.
                if (bus.WR_EN) begin
                    r_pending <= bus.WR_DATA;
                    r_pend    <= 1'b1;
                end
            end
        end
    end

`ifdef COUNTER_RELOAD_MATCH_EN
    logic [WIDTH-1:0] r_match_val;
    logic             r_match;

    assign bus.MATCH = r_match;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_match_val <= '0;
            r_match     <= 1'b0;
        end else begin
            if (bus.MATCH_WR)
                r_match_val <= bus.MATCH_DATA;
            r_match <= w_run & (bus.CNT_O == r_match_val);
        end
    end
`endif
endmodule
